// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller pad interface blocks.
// Button order matches the order the pad shifts its bits out.
package nes_pkg;

    localparam int NUM_BTN     = 8;
    localparam int LATCH_TICKS = 2;
    localparam int BIT_IDX_W   = $clog2(NUM_BTN);
    localparam int LATCH_CNT_W = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_READ,
        ST_PULSE
    } state_e;

endpackage

// File: rtl/nes_tick_gen.sv
// Prescaler producing a one-clk tick every TICK_DIV clocks.
// A synchronous clear restarts the period so the first tick lands exactly TICK_DIV clocks later.
module nes_tick_gen #(
    parameter int TICK_DIV = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick_o = (count_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_i || tick_o) begin
            count_d = '0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nes_shift_in.sv
// Drives the NES pad LATCH/PULSE pins and shifts in its 8 active-low button bits,
// presenting an active-high button vector with valid and changed strobes.
module nes_shift_in
    import nes_pkg::*;
#(
    parameter int TICK_DIV = 300
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               latch_i,
    input  logic               nes_data_i,
    output logic               nes_latch_o,
    output logic               nes_pulse_o,
    output logic [NUM_BTN-1:0] buttons_o,
    output logic               valid_o,
    output logic               changed_o,
    output logic               busy_o
);

    state_e                   state_q, state_d;
    logic [BIT_IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [LATCH_CNT_W-1:0]   latch_cnt_q, latch_cnt_d;
    logic [NUM_BTN-2:0]       shreg_q, shreg_d;
    logic [NUM_BTN-1:0]       buttons_q, buttons_d;
    logic                     valid_q, valid_d;
    logic                     changed_q, changed_d;
    logic                     nes_latch_q, nes_latch_d;
    logic                     nes_pulse_q, nes_pulse_d;
    logic                     latch_q;
    logic                     sync1_q, sync2_q;

    logic                     trigger;
    logic                     tick;
    logic [NUM_BTN-1:0]       commit_val;

    assign trigger    = latch_i & ~latch_q & (state_q == ST_IDLE);
    assign commit_val = ~{sync2_q, shreg_q};

    nes_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .clear_i (trigger),
        .tick_o  (tick)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        latch_cnt_d = latch_cnt_q;
        shreg_d     = shreg_q;
        buttons_d   = buttons_q;
        valid_d     = 1'b0;
        changed_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d     = ST_LATCH;
                    bit_idx_d   = '0;
                    latch_cnt_d = '0;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    if (latch_cnt_q == LATCH_CNT_W'(LATCH_TICKS - 1)) begin
                        state_d = ST_READ;
                    end else begin
                        latch_cnt_d = latch_cnt_q + LATCH_CNT_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (tick) begin
                    if (bit_idx_q == BIT_IDX_W'(NUM_BTN - 1)) begin
                        // Final bit goes straight into the committed vector, not the shift register.
                        buttons_d = commit_val;
                        valid_d   = 1'b1;
                        changed_d = (commit_val != buttons_q);
                        state_d   = ST_IDLE;
                    end else begin
                        shreg_d[bit_idx_q] = sync2_q;
                        state_d            = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (tick) begin
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    state_d   = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin levels follow the next state so they toggle only on state transitions.
        nes_latch_d = (state_d == ST_LATCH);
        nes_pulse_d = (state_d == ST_PULSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            latch_cnt_q <= '0;
            shreg_q     <= '0;
            buttons_q   <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            nes_latch_q <= 1'b0;
            nes_pulse_q <= 1'b0;
            latch_q     <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            latch_cnt_q <= latch_cnt_d;
            shreg_q     <= shreg_d;
            buttons_q   <= buttons_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            nes_latch_q <= nes_latch_d;
            nes_pulse_q <= nes_pulse_d;
            latch_q     <= latch_i;
            sync1_q     <= nes_data_i;
            sync2_q     <= sync1_q;
        end
    end

    assign nes_latch_o = nes_latch_q;
    assign nes_pulse_o = nes_pulse_q;
    assign buttons_o   = buttons_q;
    assign valid_o     = valid_q;
    assign changed_o   = changed_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nes_shift_in.sv
// Bench for nes_shift_in: a behavioural NES pad plus a frame-level reference model
// checking pin timing, latency, committed buttons and the changed strobe.
module tb_nes_shift_in;
    import nes_pkg::*;

    localparam int TD = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               latch_i;
    logic               nes_data_i;
    logic               nes_latch_o;
    logic               nes_pulse_o;
    logic [NUM_BTN-1:0] buttons_o;
    logic               valid_o;
    logic               changed_o;
    logic               busy_o;

    int errors = 0;
    int checks = 0;

    nes_shift_in #(
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .latch_i     (latch_i),
        .nes_data_i  (nes_data_i),
        .nes_latch_o (nes_latch_o),
        .nes_pulse_o (nes_pulse_o),
        .buttons_o   (buttons_o),
        .valid_o     (valid_o),
        .changed_o   (changed_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Pad model: LATCH reloads, each PULSE rising edge shifts the next bit out.
    logic [7:0] pad_lo = 8'hFF;
    bit         pad_connected = 1'b1;
    int         pad_idx = 8;

    always @(posedge nes_latch_o) pad_idx = 0;
    always @(posedge nes_pulse_o) pad_idx = pad_idx + 1;

    always_comb begin
        if (!pad_connected || pad_idx > 7) nes_data_i = 1'b1;
        else                               nes_data_i = pad_lo[pad_idx];
    end

    // Reference: last committed button vector (0 after reset).
    logic [7:0] prev_btn = 8'h00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // mode 0: short latch pulse; 1: extra latch edges mid-frame; 2: latch held high 200 clks
    task automatic run_frame(input string name, input logic [7:0] pressed,
                             input bit connected, input int mode);
        logic [7:0] exp_btn;
        logic       exp_chg;
        int         lat = -1;
        int         latch_hi = 0;
        int         busy_n = 0;
        int         rises = 0;
        int         first_rise = -1;
        int         last_rise = -1;
        int         pulse_hi = 0;
        int         extra_valid = 0;
        int         cyc = 0;
        logic       prev_pulse = 1'b0;
        bit         got = 1'b0;
        logic [7:0] got_btn = 8'h00;
        logic       got_chg = 1'b0;

        exp_btn = connected ? pressed : 8'h00;
        exp_chg = (exp_btn != prev_btn);
        pad_lo = ~pressed;
        pad_connected = connected;

        @(negedge clk);
        latch_i = 1'b1;
        while (!got && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (nes_latch_o) latch_hi++;
            if (busy_o) busy_n++;
            if (nes_pulse_o) pulse_hi++;
            if (nes_pulse_o && !prev_pulse) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
                last_rise = cyc;
            end
            prev_pulse = nes_pulse_o;
            if (valid_o) begin
                got = 1'b1;
                lat = cyc - 1;
                got_btn = buttons_o;
                got_chg = changed_o;
            end
            if (mode != 2 && cyc == 2) latch_i = 1'b0;
            if (mode == 1) begin
                if (cyc == 9 || cyc == 39)  latch_i = 1'b1;
                if (cyc == 11 || cyc == 41) latch_i = 1'b0;
            end
        end

        check({name, " valid_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, 32'(lat), 32'(17 * TD));
            check({name, " buttons"}, 32'(got_btn), 32'(exp_btn));
            check({name, " changed"}, 32'(got_chg), 32'(exp_chg));
            check({name, " latch_clks"}, 32'(latch_hi), 32'(LATCH_TICKS * TD));
            check({name, " busy_clks"}, 32'(busy_n), 32'(17 * TD));
            check({name, " pulse_count"}, 32'(rises), 32'd7);
            check({name, " pulse_high_clks"}, 32'(pulse_hi), 32'(7 * TD));
            check({name, " first_pulse"}, 32'(first_rise), 32'(3 * TD + 1));
            check({name, " last_pulse"}, 32'(last_rise), 32'(15 * TD + 1));
        end

        // Tail: release latch (mode 2 at 200 clks) and confirm no further read starts.
        while (cyc < 200 && mode == 2) begin
            @(posedge clk);
            #1;
            cyc++;
            if (valid_o || busy_o) extra_valid++;
        end
        latch_i = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid_o || busy_o) extra_valid++;
        end
        check({name, " no_extra_read"}, 32'(extra_valid), 32'd0);
        check({name, " buttons_hold"}, 32'(buttons_o), 32'(exp_btn));
        prev_btn = exp_btn;
    endtask

    task automatic mid_reset(input logic [7:0] pressed);
        int         seen = 0;
        logic [7:0] acc = 8'h00;
        pad_lo = ~pressed;
        pad_connected = 1'b1;
        @(negedge clk);
        latch_i = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) latch_i = 1'b0;
        end
        check("rst busy_before", 32'(busy_o), 32'd1);
        reset = 1'b1;
        #1;
        check("rst async_outputs", 32'({busy_o, nes_latch_o, nes_pulse_o, valid_o, changed_o, buttons_o}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (valid_o || busy_o || nes_latch_o || nes_pulse_o || changed_o) seen++;
            acc = acc | buttons_o;
        end
        check("rst no_activity", 32'(seen), 32'd0);
        check("rst buttons_zero", 32'(acc), 32'd0);
        prev_btn = 8'h00;
    endtask

    initial begin
        logic [7:0] pat;
        reset   = 1'b1;
        latch_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({busy_o, nes_latch_o, nes_pulse_o, valid_o, changed_o, buttons_o}), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        run_frame("a_start_1", 8'h09, 1'b1, 0);
        run_frame("a_start_2", 8'h09, 1'b1, 0);
        run_frame("right", 8'h80, 1'b1, 0);
        run_frame("extra_edges", 8'h80, 1'b1, 1);

        for (int i = 0; i < 6; i++) begin
            pat = 8'($urandom);
            repeat ($urandom_range(0, 10)) @(negedge clk);
            run_frame($sformatf("rand%0d", i), pat, 1'b1, int'($urandom_range(0, 1)));
        end

        run_frame("pre_reset", 8'h5A, 1'b1, 0);
        mid_reset(8'hC3);
        run_frame("post_reset", 8'hC3, 1'b1, 0);
        run_frame("held_latch", 8'h00, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
